// File: rtl/accum_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_feeder_pkg
// Description : Shared types and constants for the accumulator feeder.
// Revision    : 1.0  initial release
// ============================================================================
package accum_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int          ACCUM_W           = 32;
    localparam logic [31:0] ADD_CONST_DEFAULT = 32'd7;

endpackage
`default_nettype wire

// File: rtl/feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : feeder_fifo
// Description : Power-of-two FIFO with head output, occupancy and clear.
// Revision    : 1.0  initial release
// ============================================================================
module feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/accum_feeder.sv
`default_nettype none
// ============================================================================
// Module      : accum_feeder
// Description : Buffers words and issues them to a gated-clock accumulator,
//               tracking the accumulator's expected value in a shadow register.
// Revision    : 1.0  initial release
// ============================================================================
module accum_feeder
    import accum_feeder_pkg::*;
#(
    parameter int                 DEPTH     = 4,
    parameter logic [ACCUM_W-1:0] ADD_CONST = ADD_CONST_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [ACCUM_W-1:0]       i_in_data,
    input  logic                     i_start,
    input  logic                     i_flush,
    output logic [ACCUM_W-1:0]       o_accum_in,
    output logic                     o_clk_en,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [ACCUM_W-1:0]       o_expected,
    output logic [15:0]              o_issued
);

    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ACCUM_W-1:0] r_accum_in;
    logic               r_clk_en;
    logic [ACCUM_W-1:0] r_expected;
    logic [15:0]        r_issued;

    logic [CW-1:0]      w_count;
    logic [ACCUM_W-1:0] w_head;
    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_clear;

    assign w_in_ready = (w_count < CW'(DEPTH)) && (r_state != S_DRAIN);
    assign w_push     = i_in_valid && w_in_ready;
    assign w_pop      = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (w_count != '0);
    assign w_clear    = (r_state == S_IDLE) && i_flush && !i_start;

    feeder_fifo #(
        .DEPTH (DEPTH),
        .W     (ACCUM_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (i_in_data),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (i_flush) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_count == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The consumer latches clk_en while clk is low, so both issue outputs
    // must come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_accum_in <= '0;
            r_clk_en   <= 1'b0;
            r_expected <= '0;
            r_issued   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_clk_en <= w_pop;
            if (w_pop) r_accum_in <= w_head;
            if (r_clk_en) begin
                r_expected <= r_expected + r_accum_in + ADD_CONST;
                r_issued   <= r_issued + 16'd1;
            end
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_accum_in = r_accum_in;
    assign o_clk_en   = r_clk_en;
    assign o_busy     = (r_state != S_IDLE) || r_clk_en;
    assign o_count    = w_count;
    assign o_expected = r_expected;
    assign o_issued   = r_issued;

endmodule
`default_nettype wire

// File: tb/tb_accum_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_feeder
// Description : Directed self-checking bench for accum_feeder with scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_accum_feeder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] ADDC  = 32'd7;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_in_data;
    logic        i_start;
    logic        i_flush;
    logic [31:0] o_accum_in;
    logic        o_clk_en;
    logic        o_busy;
    logic [2:0]  o_count;
    logic [31:0] o_expected;
    logic [15:0] o_issued;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    logic [31:0] m_exp = 32'd0;
    logic [15:0] m_iss = 16'd0;
    bit          mon_en = 1'b0;

    accum_feeder #(.DEPTH(DEPTH), .ADD_CONST(ADDC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_data  (i_in_data),
        .i_start    (i_start),
        .i_flush    (i_flush),
        .o_accum_in (o_accum_in),
        .o_clk_en   (o_clk_en),
        .o_busy     (o_busy),
        .o_count    (o_count),
        .o_expected (o_expected),
        .o_issued   (o_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every issued word must match the next queued word.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("expected", o_expected, m_exp);
            check("issued", 32'(o_issued), 32'(m_iss));
            if (o_clk_en) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_empty observed=clk_en expected=no_issue");
                end
                if (sb.size() != 0) begin
                    logic [31:0] v;
                    v = sb.pop_front();
                    check("accum_in", o_accum_in, v);
                    m_exp = m_exp + v + ADDC;
                    m_iss = m_iss + 16'd1;
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        sb.delete();
        m_exp = 32'd0;
        m_iss = 16'd0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Leaves i_in_valid high so consecutive calls keep the stream continuous.
    task automatic push_word(input logic [31:0] d);
        bit rdy;
        bit done;
        done = 1'b0;
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            #1 rdy = o_in_ready;
            @(posedge clk);
            if (rdy) begin
                sb.push_back(d);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic idle_in();
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        check("idle_reached", 32'(o_busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic go_idle();
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_in_valid = 1'b0;
        i_in_data  = 32'd0;
        i_start    = 1'b0;
        i_flush    = 1'b0;
        rst_n      = 1'b1;
        #1;
        do_reset();

        // Reset state
        check("rst_accum_in", o_accum_in, 32'd0);
        check("rst_clk_en", 32'(o_clk_en), 32'd0);
        check("rst_expected", o_expected, 32'd0);
        check("rst_issued", 32'(o_issued), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_in_ready", 32'(o_in_ready), 32'd1);

        // Preload 1,2,3 then start
        push_word(32'd1);
        push_word(32'd2);
        push_word(32'd3);
        idle_in();
        check("preload_count", 32'(o_count), 32'd3);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("lat_n_clk_en", 32'(o_clk_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("run_clk_en", 32'(o_clk_en), 32'd1);
            check("run_accum_in_direct", o_accum_in, 32'(k + 1));
        end
        @(negedge clk);
        check("run_done_clk_en", 32'(o_clk_en), 32'd0);
        check("run_expected_27", o_expected, 32'd27);
        check("run_issued_3", 32'(o_issued), 32'd3);
        go_idle();

        // Backpressure: hold valid for five words
        for (int i = 0; i < 4; i++) push_word(32'(10 + i));
        @(negedge clk);
        i_in_data = 32'd14;
        #1;
        check("bp_full_count", 32'(o_count), 32'd4);
        check("bp_full_ready", 32'(o_in_ready), 32'd0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check("bp_run_full_ready", 32'(o_in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("bp_first_pop_clk_en", 32'(o_clk_en), 32'd1);
        check("bp_after_pop_count", 32'(o_count), 32'd3);
        check("bp_after_pop_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(32'd14);
        @(negedge clk);
        i_in_valid = 1'b0;
        check("bp_push_pop_count", 32'(o_count), 32'd3);
        go_idle();

        // Flush in RUN with two queued words
        push_word(32'd21);
        push_word(32'd22);
        idle_in();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_flush = 1'b1;
        check("fr_count_2", 32'(o_count), 32'd2);
        @(negedge clk);
        i_flush = 1'b0;
        check("fr_d1_ready", 32'(o_in_ready), 32'd0);
        check("fr_d1_clk_en", 32'(o_clk_en), 32'd1);
        check("fr_d1_count", 32'(o_count), 32'd1);
        @(negedge clk);
        check("fr_d2_ready", 32'(o_in_ready), 32'd0);
        check("fr_d2_clk_en", 32'(o_clk_en), 32'd1);
        check("fr_d2_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        check("fr_idle_clk_en", 32'(o_clk_en), 32'd0);
        check("fr_idle_busy", 32'(o_busy), 32'd0);
        check("fr_idle_ready", 32'(o_in_ready), 32'd1);

        // Flush in IDLE discards; start+flush issues
        push_word(32'd31);
        push_word(32'd32);
        push_word(32'd33);
        idle_in();
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        sb.delete();
        check("fi_count", 32'(o_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fi_no_clk_en", 32'(o_clk_en), 32'd0);
        end
        check("fi_expected", o_expected, m_exp);
        check("fi_issued", 32'(o_issued), 32'(m_iss));
        push_word(32'd99);
        idle_in();
        i_start = 1'b1;
        i_flush = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_flush = 1'b0;
        check("sf_count_kept", 32'(o_count), 32'd1);
        @(negedge clk);
        check("sf_clk_en", 32'(o_clk_en), 32'd1);
        check("sf_accum_in", o_accum_in, 32'd99);
        go_idle();

        // Wrap from zero
        do_reset();
        push_word(32'hFFFF_FFF9);
        idle_in();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("wrap_expected_0", o_expected, 32'd0);
        check("wrap_issued_1", 32'(o_issued), 32'd1);
        push_word(32'd5);
        idle_in();
        repeat (3) @(negedge clk);
        check("wrap_expected_12", o_expected, 32'd12);
        go_idle();

        // Async reset mid-RUN
        do_reset();
        for (int i = 0; i < 4; i++) push_word(32'(40 + i));
        idle_in();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("ar_pre_clk_en", 32'(o_clk_en), 32'd1);
        check("ar_pre_count", 32'(o_count), 32'd2);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_clk_en", 32'(o_clk_en), 32'd0);
        check("ar_count", 32'(o_count), 32'd0);
        check("ar_in_ready", 32'(o_in_ready), 32'd1);
        check("ar_expected", o_expected, 32'd0);
        check("ar_busy", 32'(o_busy), 32'd0);
        check("ar_issued", 32'(o_issued), 32'd0);
        @(negedge clk);
        do_reset();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
